rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_pkg.sv | 19 +
 rtl/rst_seq_ctrl_sync.sv | 29 ++
 rtl/rst_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the counter-width function used to size the hold/gap counter.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_STRETCH,
    ST_RELEASE,
    ST_RUN
  } rst_state_t;

  // Bits needed to count up to max(hold, gap) inclusive.
  function automatic int cnt_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_ctrl_sync.sv
// rst_sync_chain: NUM_STAGES-deep reset synchroniser. The D input of the first
// stage is tied high; every stage clears asynchronously on RESET low.
module rst_sync_chain #(
  parameter int NUM_STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  output logic SYNC_OUT
);

  logic [NUM_STAGES-1:0] chain_q;
  logic [NUM_STAGES-1:0] chain_d;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign chain_d[i] = 1'b1;
    end else begin : g_link
      assign chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) chain_q <= '0;
    else        chain_q <= chain_d;
  end

  assign SYNC_OUT = chain_q[NUM_STAGES-1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: synchronised reset sequencer with staggered per-channel release.
// Optional per-channel software reset is built when RST_SEQ_SWRST_EN is defined.
module rst_seq_ctrl
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES = 2,
  parameter int N_CH       = 4,
  parameter int STRETCH    = 16,
  parameter int GAP        = 8
) (
  input  logic            CLK,
  input  logic            RESET,
`ifdef RST_SEQ_SWRST_EN
  input  logic [N_CH-1:0] SW_RST,
`endif
  output logic [N_CH-1:0] SYNC_RESET,
  output logic            RST_DONE
);

  localparam int CW = cnt_width(STRETCH, GAP);
  localparam int RW = $clog2(N_CH + 1);

  if (NUM_STAGES < 2 || N_CH < 1 || N_CH > 16 || STRETCH < 1 || GAP < 0) begin : g_bad_params
    $error("rst_seq_ctrl: illegal parameter set");
  end

  logic rst_sync;

  rst_sync_chain #(.NUM_STAGES(NUM_STAGES)) u_sync (
    .CLK      (CLK),
    .RESET    (RESET),
    .SYNC_OUT (rst_sync)
  );

  rst_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [RW-1:0]   rel_q, rel_d;
  logic [N_CH-1:0] sync_reset_q, sync_reset_d;
  logic            rst_done_q, rst_done_d;
  logic            start_release;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_ASSERT;
      cnt_q        <= '0;
      rel_q        <= '0;
      sync_reset_q <= '0;
      rst_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rel_q        <= rel_d;
      sync_reset_q <= sync_reset_d;
      rst_done_q   <= rst_done_d;
    end
  end

  // The ASSERT exit edge counts as the first hold cycle, so channel 0
  // releases on the (NUM_STAGES+STRETCH)-th edge after RESET rises.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rel_d         = rel_q;
    start_release = 1'b0;
    case (state_q)
      ST_ASSERT: begin
        if (rst_sync) begin
          if (STRETCH == 1) begin
            start_release = 1'b1;
          end else begin
            state_d = ST_STRETCH;
            cnt_d   = CW'(1);
          end
        end
      end
      ST_STRETCH: begin
        if (cnt_q == CW'(STRETCH - 1)) start_release = 1'b1;
        else                           cnt_d = cnt_q + CW'(1);
      end
      ST_RELEASE: begin
        if (cnt_q == CW'(GAP)) begin
          rel_d = rel_q + RW'(1);
          cnt_d = CW'(1);
          if (rel_q == RW'(N_CH - 1)) state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: ;
    endcase
    if (start_release) begin
      cnt_d = CW'(1);
      if (GAP == 0 || N_CH == 1) begin
        rel_d   = RW'(N_CH);
        state_d = ST_RUN;
      end else begin
        rel_d   = RW'(1);
        state_d = ST_RELEASE;
      end
    end
  end

`ifdef RST_SEQ_SWRST_EN
  localparam int HW = $clog2(STRETCH + 1);

  logic [HW-1:0] hold_q [N_CH];
  logic [HW-1:0] hold_d [N_CH];

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned k = 0; k < N_CH; k++) hold_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) hold_q[k] <= hold_d[k];
    end
  end

  // A repeat request reloads the full hold count.
  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) begin
      hold_d[k] = hold_q[k];
      if (state_q == ST_RUN && SW_RST[k]) hold_d[k] = HW'(STRETCH);
      else if (hold_q[k] != '0)           hold_d[k] = hold_q[k] - HW'(1);
    end
  end
`endif

  always_comb begin
    for (int unsigned k = 0; k < N_CH; k++) sync_reset_d[k] = (32'(rel_d) > k);
    rst_done_d = (state_d == ST_RUN);
`ifdef RST_SEQ_SWRST_EN
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (hold_d[k] != '0) begin
        sync_reset_d[k] = 1'b0;
        rst_done_d      = 1'b0;
      end
    end
`endif
  end

  assign SYNC_RESET = sync_reset_q;
  assign RST_DONE   = rst_done_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: edge-count model plus literal timing
// pins for the default build and a GAP=0, N_CH=3 instance.
module tb_rst_seq_ctrl;

  localparam int NS    = 2;
  localparam int ST    = 16;
  localparam int GAP_D = 8;
  localparam int TREL  = NS + ST;
  localparam int TDONE = TREL + 3 * GAP_D;

  logic       CLK;
  logic       RESET;
  logic [3:0] sw;
  logic [3:0] sr_a;
  logic       done_a;
  logic [2:0] sr_b;
  logic       done_b;

  int n_chk  = 0;
  int n_fail = 0;
  logic run_chk = 1'b0;

  rst_seq_ctrl #(.NUM_STAGES(NS), .N_CH(4), .STRETCH(ST), .GAP(GAP_D)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
`ifdef RST_SEQ_SWRST_EN
    .SW_RST     (sw),
`endif
    .SYNC_RESET (sr_a),
    .RST_DONE   (done_a)
  );

  rst_seq_ctrl #(.NUM_STAGES(NS), .N_CH(3), .STRETCH(ST), .GAP(0)) dut_g0 (
    .CLK        (CLK),
    .RESET      (RESET),
`ifdef RST_SEQ_SWRST_EN
    .SW_RST     (3'b000),
`endif
    .SYNC_RESET (sr_b),
    .RST_DONE   (done_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: n_m = posedges seen since RESET last rose; last_sw = edge number of
  // the most recent accepted software request per channel.
  int n_m = 0;
  int last_sw [4] = '{-100000, -100000, -100000, -100000};

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      n_m <= 0;
      for (int k = 0; k < 4; k++) last_sw[k] <= -100000;
    end else begin
      n_m <= n_m + 1;
`ifdef RST_SEQ_SWRST_EN
      for (int k = 0; k < 4; k++)
        if (n_m >= TDONE && sw[k]) last_sw[k] <= n_m + 1;
`endif
    end
  end

  function automatic logic [15:0] rel_mask(input int n, input int nch, input int gap);
    logic [15:0] m;
    m = '0;
    for (int k = 0; k < nch; k++) if (n >= TREL + k * gap) m[k] = 1'b1;
    return m;
  endfunction

  always @(negedge CLK) begin
    logic [15:0] ea, eb;
    logic        eda, edb;
    if (run_chk) begin
      ea  = rel_mask(n_m, 4, GAP_D);
      eda = (n_m >= TDONE);
      for (int k = 0; k < 4; k++)
        if (n_m - last_sw[k] < ST) begin
          ea[k] = 1'b0;
          eda   = 1'b0;
        end
      eb  = rel_mask(n_m, 3, 0);
      edb = (n_m >= TREL);
      chk("model_sync_a", {12'h0, sr_a}, ea);
      chk("model_done_a", {15'h0, done_a}, {15'h0, eda});
      chk("model_sync_b", {13'h0, sr_b}, eb);
      chk("model_done_b", {15'h0, done_b}, {15'h0, edb});
    end
  end

  task automatic step(input int k);
    repeat (k) begin
      @(posedge CLK);
      #2;
    end
  endtask

  // RESET has just risen; walk 45 edges, pinning the hand-computed release
  // edges, optionally injecting an SW_RST pulse sampled at edge sw_edge.
  task automatic run_seq(input int sw_edge, input logic [3:0] v);
    if (sw_edge == 1) sw = v;
    for (int e = 1; e <= 45; e++) begin
      step(1);
      if (e == sw_edge) sw = 4'b0000;
      if (e + 1 == sw_edge) sw = v;
      case (e)
        17: begin
          chk("lit_a_e17", {12'h0, sr_a}, 16'h0000);
          chk("lit_b_e17", {13'h0, sr_b}, 16'h0000);
          chk("lit_doneb_e17", {15'h0, done_b}, 16'h0000);
        end
        18: begin
          chk("lit_a_e18", {12'h0, sr_a}, 16'h0001);
          chk("lit_b_e18", {13'h0, sr_b}, 16'h0007);
          chk("lit_doneb_e18", {15'h0, done_b}, 16'h0001);
        end
        25: chk("lit_a_e25", {12'h0, sr_a}, 16'h0001);
        26: chk("lit_a_e26", {12'h0, sr_a}, 16'h0003);
        33: chk("lit_a_e33", {12'h0, sr_a}, 16'h0003);
        34: chk("lit_a_e34", {12'h0, sr_a}, 16'h0007);
        41: begin
          chk("lit_a_e41", {12'h0, sr_a}, 16'h0007);
          chk("lit_donea_e41", {15'h0, done_a}, 16'h0000);
        end
        42: begin
          chk("lit_a_e42", {12'h0, sr_a}, 16'h000F);
          chk("lit_donea_e42", {15'h0, done_a}, 16'h0001);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    RESET = 1'b0;
    sw    = 4'b0000;
    step(3);
    run_chk = 1'b1;
    chk("reset_sync_a", {12'h0, sr_a}, 16'h0000);
    chk("reset_done_a", {15'h0, done_a}, 16'h0000);
    RESET = 1'b1;
    run_seq(0, 4'b0000);

    // Abort three cycles after channel 1 releases, then rerun.
    RESET = 1'b0;
    step(2);
    RESET = 1'b1;
    for (int e = 1; e <= 29; e++) begin
      step(1);
      if (e == 26) chk("abort_pre_e26", {12'h0, sr_a}, 16'h0003);
    end
    RESET = 1'b0;
    #1;
    chk("abort_async_sync", {12'h0, sr_a}, 16'h0000);
    chk("abort_async_done", {15'h0, done_a}, 16'h0000);
    step(3);
    RESET = 1'b1;
    run_seq(0, 4'b0000);

    // Sub-period RESET glitch while in RUN.
    RESET = 1'b0;
    #1;
    chk("glitch_async_sync", {12'h0, sr_a}, 16'h0000);
    chk("glitch_async_doneb", {15'h0, done_b}, 16'h0000);
    #1;
    RESET = 1'b1;
    run_seq(0, 4'b0000);

`ifdef RST_SEQ_SWRST_EN
    sw = 4'b0101;
    step(1);
    sw = 4'b0000;
    chk("sw_hold_start", {12'h0, sr_a}, 16'h000A);
    chk("sw_hold_done", {15'h0, done_a}, 16'h0000);
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (i == 15) chk("sw_hold_last", {12'h0, sr_a}, 16'h000A);
      if (i == 16) begin
        chk("sw_hold_end", {12'h0, sr_a}, 16'h000F);
        chk("sw_hold_end_done", {15'h0, done_a}, 16'h0001);
      end
    end

    sw = 4'b0100;
    step(1);
    sw = 4'b0000;
    step(9);
    sw = 4'b0100;
    step(1);
    sw = 4'b0000;
    step(15);
    chk("sw_retrig_e25", {12'h0, sr_a}, 16'h000B);
    step(1);
    chk("sw_retrig_e26", {12'h0, sr_a}, 16'h000F);

    RESET = 1'b0;
    step(2);
    RESET = 1'b1;
    run_seq(21, 4'b1111);
    RESET = 1'b0;
    step(2);
    RESET = 1'b1;
    run_seq(42, 4'b0100);
    chk("sw_release_ignored", {12'h0, sr_a}, 16'h000F);
`endif

    step(2);
    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
